// File: rtl/plru_array.sv
// Tree pseudo-LRU replacement state for a set-associative cache: one binary
// tree of NUM_WAYS-1 bits per set, updated on access and walked for victims.
module plru_array #(
    parameter  int NUM_WAYS = 4,
    parameter  int NUM_SETS = 32,
    localparam int WAY_W    = $clog2(NUM_WAYS),
    localparam int SET_W    = $clog2(NUM_SETS),
    localparam int NODES    = NUM_WAYS - 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                access_valid,
    input  logic [SET_W-1:0]    access_set,
    input  logic [WAY_W-1:0]    access_way,
    input  logic                victim_req,
    input  logic [SET_W-1:0]    victim_set,
    input  logic [NUM_WAYS-1:0] way_valid,
    output logic                victim_rdy,
    output logic [WAY_W-1:0]    victim_way,
    output logic                busy
);

    typedef enum logic {SWEEP, IDLE} state_e;

    state_e             state_q, state_d;
    logic [SET_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               victim_rdy_q, victim_rdy_d;
    logic [WAY_W-1:0]   victim_way_q, victim_way_d;

    logic [NODES-1:0]   tree_q [NUM_SETS];
    logic               tree_we;
    logic [SET_W-1:0]   tree_wa;
    logic [NODES-1:0]   tree_wd;

    logic [NODES-1:0]   acc_tree;
    logic [NODES-1:0]   vic_tree;
    logic [WAY_W-1:0]   sel_way;

    // Point every node on the path to `way` away from it (heap order, MSB at root).
    function automatic logic [NODES-1:0] touch(input logic [NODES-1:0] bits,
                                               input logic [WAY_W-1:0] way);
        logic [NODES-1:0] r;
        logic [WAY_W-1:0] node;
        logic [WAY_W-1:0] w;
        logic             b;
        r    = bits;
        node = '0;
        w    = way;
        for (int unsigned l = 0; l < WAY_W; l++) begin
            b       = w[WAY_W-1];
            r[node] = ~b;
            node    = WAY_W'(2 * 32'(node) + 32'(b) + 1);
            w       = w << 1;
        end
        return r;
    endfunction

    function automatic logic [WAY_W-1:0] walk(input logic [NODES-1:0] bits);
        logic [WAY_W-1:0] node;
        logic [WAY_W-1:0] way;
        logic             b;
        node = '0;
        way  = '0;
        for (int unsigned l = 0; l < WAY_W; l++) begin
            b    = bits[node];
            way  = WAY_W'({way, b});
            node = WAY_W'(2 * 32'(node) + 32'(b) + 1);
        end
        return way;
    endfunction

    function automatic logic [WAY_W-1:0] choose(input logic [NUM_WAYS-1:0] valid,
                                                input logic [NODES-1:0] bits);
        logic [NUM_WAYS-1:0] v;
        logic [WAY_W-1:0]    way;
        logic                found;
        v     = valid;
        way   = walk(bits);
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_WAYS; i++) begin
            if (!found && !v[0]) begin
                way   = WAY_W'(i);
                found = 1'b1;
            end
            v = v >> 1;
        end
        return way;
    endfunction

    always_comb begin
        acc_tree = touch(tree_q[access_set], access_way);
        // A same-cycle access to the requested set is visible to the victim pick.
        vic_tree = (access_valid && (access_set == victim_set)) ? acc_tree
                                                                : tree_q[victim_set];
        sel_way  = choose(way_valid, vic_tree);

        state_d      = state_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        victim_rdy_d = 1'b0;
        victim_way_d = victim_way_q;
        tree_we      = 1'b0;
        tree_wa      = cnt_q;
        tree_wd      = '0;

        case (state_q)
            SWEEP: begin
                tree_we = 1'b1;
                tree_wa = cnt_q;
                tree_wd = '0;
                if (cnt_q == SET_W'(NUM_SETS - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (access_valid) begin
                    tree_we = 1'b1;
                    tree_wa = access_set;
                    tree_wd = acc_tree;
                end
                victim_rdy_d = victim_req;
                if (victim_req) begin
                    victim_way_d = sel_way;
                end
            end
            default: begin
                state_d = SWEEP;
            end
        endcase

        if (!rst_n) begin
            tree_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= SWEEP;
            cnt_q        <= '0;
            busy_q       <= 1'b1;
            victim_rdy_q <= 1'b0;
            victim_way_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            victim_rdy_q <= victim_rdy_d;
            victim_way_q <= victim_way_d;
        end
    end

    // Tree storage has no reset of its own; the sweep clears it.
    always_ff @(posedge clk) begin
        if (tree_we) begin
            tree_q[tree_wa] <= tree_wd;
        end
    end

    assign victim_rdy = victim_rdy_q;
    assign victim_way = victim_way_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_plru_array.sv
// Directed check of plru_array with 4 ways and 8 sets: sweep timing, tree
// update/walk, forwarding, invalid-way priority and reset during sweep.
module tb_plru_array;

    localparam int NW = 4;
    localparam int NS = 8;

    logic       clk;
    logic       rst_n;
    logic       access_valid;
    logic [2:0] access_set;
    logic [1:0] access_way;
    logic       victim_req;
    logic [2:0] victim_set;
    logic [3:0] way_valid;
    logic       victim_rdy;
    logic [1:0] victim_way;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    plru_array #(.NUM_WAYS(NW), .NUM_SETS(NS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .access_valid (access_valid),
        .access_set   (access_set),
        .access_way   (access_way),
        .victim_req   (victim_req),
        .victim_set   (victim_set),
        .way_valid    (way_valid),
        .victim_rdy   (victim_rdy),
        .victim_way   (victim_way),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        access_valid = 1'b0;
        access_set   = '0;
        access_way   = '0;
        victim_req   = 1'b0;
        victim_set   = '0;
        way_valid    = 4'b1111;
    endtask

    task automatic vreq(input logic [2:0] s, input logic [3:0] wv);
        victim_req = 1'b1;
        victim_set = s;
        way_valid  = wv;
    endtask

    task automatic acc(input logic [2:0] s, input logic [1:0] w);
        access_valid = 1'b1;
        access_set   = s;
        access_way   = w;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        check("reset_busy", 32'(busy), 32'd1);
        check("reset_rdy", 32'(victim_rdy), 32'd0);
        check("reset_way", 32'(victim_way), 32'd0);

        // Sweep of 8 sets after release
        rst_n = 1'b1;
        for (int i = 1; i <= NS; i++) begin
            tick();
            check($sformatf("sweep_busy_%0d", i), 32'(busy), (i < NS) ? 32'd1 : 32'd0);
        end

        vreq(3'd5, 4'b1111);
        tick();
        idle_inputs();
        check("fresh_rdy", 32'(victim_rdy), 32'd1);
        check("fresh_way", 32'(victim_way), 32'd0);
        tick();
        check("rdy_drop", 32'(victim_rdy), 32'd0);

        // Access set3 way0: root=1, node1=1 -> victim way 2
        acc(3'd3, 2'd0);
        tick();
        idle_inputs();
        vreq(3'd3, 4'b1111);
        tick();
        idle_inputs();
        check("s3w0_rdy", 32'(victim_rdy), 32'd1);
        check("s3w0_way", 32'(victim_way), 32'd2);
        tick();
        check("hold_rdy", 32'(victim_rdy), 32'd0);
        check("hold_way", 32'(victim_way), 32'd2);

        // Access set3 way2: root=0, node2=1 -> victim way 1
        acc(3'd3, 2'd2);
        tick();
        idle_inputs();
        vreq(3'd3, 4'b1111);
        tick();
        idle_inputs();
        check("s3w2_way", 32'(victim_way), 32'd1);

        // Same-cycle access and victim on set 6 (forwarded)
        acc(3'd6, 2'd0);
        vreq(3'd6, 4'b1111);
        tick();
        idle_inputs();
        check("fwd_rdy", 32'(victim_rdy), 32'd1);
        check("fwd_way", 32'(victim_way), 32'd2);

        // Set 3 unaffected by set 6 traffic
        vreq(3'd3, 4'b1111);
        tick();
        idle_inputs();
        check("s3_indep", 32'(victim_way), 32'd1);

        // Invalid-way priority overrides the tree
        vreq(3'd3, 4'b1011);
        tick();
        check("inv_1011", 32'(victim_way), 32'd2);
        vreq(3'd3, 4'b0000);
        tick();
        check("inv_0000", 32'(victim_way), 32'd0);
        vreq(3'd6, 4'b0111);
        tick();
        idle_inputs();
        check("inv_0111", 32'(victim_way), 32'd3);

        // Victim request on the reset edge is dropped
        vreq(3'd3, 4'b1111);
        rst_n = 1'b0;
        tick();
        idle_inputs();
        check("rst_drop_rdy", 32'(victim_rdy), 32'd0);
        check("rst_way_clr", 32'(victim_way), 32'd0);
        rst_n = 1'b1;

        // Sweep to counter 4 with requests ignored
        for (int i = 1; i <= 4; i++) begin
            acc(3'd5, 2'd1);
            vreq(3'd5, 4'b1111);
            tick();
            check($sformatf("busy_req_rdy_%0d", i), 32'(victim_rdy), 32'd0);
            check($sformatf("busy_req_busy_%0d", i), 32'(busy), 32'd1);
        end

        // Reset mid-sweep restarts the full sweep
        rst_n = 1'b0;
        tick();
        check("mid_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b1;
        for (int i = 1; i <= NS; i++) begin
            acc(3'(i - 1), 2'(i));
            vreq(3'(i - 1), 4'b1111);
            tick();
            check($sformatf("resweep_rdy_%0d", i), 32'(victim_rdy), 32'd0);
            check($sformatf("resweep_busy_%0d", i), 32'(busy), (i < NS) ? 32'd1 : 32'd0);
        end
        idle_inputs();

        // Every set cleared: victim way 0
        for (int s = 0; s < NS; s++) begin
            vreq(3'(s), 4'b1111);
            tick();
            check($sformatf("clear_rdy_s%0d", s), 32'(victim_rdy), 32'd1);
            check($sformatf("clear_way_s%0d", s), 32'(victim_way), 32'd0);
        end
        idle_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
